// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution window scheduler and its address
// generator: scheduler state encoding, output-plane dimension helper, and the
// operand/accumulator widths of the 16-bit MAC datapath.
// No ports (package).
// ----------------------------------------------------------------------------
package conv_pkg;

    // MAC datapath widths: 16-bit operands, 32-bit signed window sums.
    localparam int OPERAND_W = 16;
    localparam int ACC_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_MAC,
        WRITE,
        FINISH
    } conv_sched_state_t;

    // Number of window positions along one dimension of the output plane.
    function automatic int calc_out_dim(input int imgDim, input int kSize, input int stride);
        return (imgDim - kSize) / stride + 1;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// ----------------------------------------------------------------------------
// window_addr_gen
// Holds the kernel-term counters (kx, ky) and window-position counters
// (ocol, orow) and turns them into memory read addresses and the output index.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   i_clear      in   force all counters to 0
//   i_step       in   advance to the next kernel term (kx, then ky)
//   i_nextWin    in   advance to the next window (ocol, then orow)
//   o_pixAddr    out  pixel address of the current term
//   o_wgtAddr    out  weight address of the current term
//   o_outAddr    out  output index of the current window
//   o_firstTerm  out  current term is kx=0, ky=0
//   o_lastTerm   out  current term is kx=K-1, ky=K-1
//   o_lastWin    out  current window is the bottom-right one
// ----------------------------------------------------------------------------
module window_addr_gen
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int STRIDE      = 1,
    parameter int ADDR_W      = 10,
    parameter int WADDR_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_step,
    input  logic               i_nextWin,
    output logic [ADDR_W-1:0]  o_pixAddr,
    output logic [WADDR_W-1:0] o_wgtAddr,
    output logic [ADDR_W-1:0]  o_outAddr,
    output logic               o_firstTerm,
    output logic               o_lastTerm,
    output logic               o_lastWin
);

    localparam int OUT_W = calc_out_dim(IMG_WIDTH, KERNEL_SIZE, STRIDE);
    localparam int OUT_H = calc_out_dim(IMG_HEIGHT, KERNEL_SIZE, STRIDE);

    localparam logic [WADDR_W-1:0] C_K_LAST   = WADDR_W'(KERNEL_SIZE - 1);
    localparam logic [WADDR_W-1:0] C_K        = WADDR_W'(KERNEL_SIZE);
    localparam logic [ADDR_W-1:0]  C_STRIDE   = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0]  C_IMG_W    = ADDR_W'(IMG_WIDTH);
    localparam logic [ADDR_W-1:0]  C_OUT_W    = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0]  C_OCOL_MAX = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0]  C_OROW_MAX = ADDR_W'(OUT_H - 1);

    logic [WADDR_W-1:0] r_kx;
    logic [WADDR_W-1:0] r_ky;
    logic [ADDR_W-1:0]  r_ocol;
    logic [ADDR_W-1:0]  r_orow;

    logic [ADDR_W-1:0]  w_rowIdx;
    logic [ADDR_W-1:0]  w_colIdx;

    // Term counters run row-major over the kernel; window counters run
    // row-major over the output plane. Both wrap to 0 after their last value,
    // so the next window/run starts from a clean origin without extra clears.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_kx   <= '0;
            r_ky   <= '0;
            r_ocol <= '0;
            r_orow <= '0;
        end else begin
            if (i_step) begin
                if (r_kx == C_K_LAST) begin
                    r_kx <= '0;
                    r_ky <= (r_ky == C_K_LAST) ? '0 : r_ky + 1'b1;
                end else begin
                    r_kx <= r_kx + 1'b1;
                end
            end
            if (i_nextWin) begin
                if (r_ocol == C_OCOL_MAX) begin
                    r_ocol <= '0;
                    r_orow <= (r_orow == C_OROW_MAX) ? '0 : r_orow + 1'b1;
                end else begin
                    r_ocol <= r_ocol + 1'b1;
                end
            end
        end
    end

    // Image coordinates of the current term inside the current window.
    assign w_rowIdx = r_orow * C_STRIDE + ADDR_W'(r_ky);
    assign w_colIdx = r_ocol * C_STRIDE + ADDR_W'(r_kx);

    assign o_pixAddr   = w_rowIdx * C_IMG_W + w_colIdx;
    assign o_wgtAddr   = r_ky * C_K + r_kx;
    assign o_outAddr   = r_orow * C_OUT_W + r_ocol;
    assign o_firstTerm = (r_kx == '0) && (r_ky == '0);
    assign o_lastTerm  = (r_kx == C_K_LAST) && (r_ky == C_K_LAST);
    assign o_lastWin   = (r_ocol == C_OCOL_MAX) && (r_orow == C_OROW_MAX);

endmodule

// File: rtl/conv_window_scheduler.sv
// ----------------------------------------------------------------------------
// conv_window_scheduler
// Walks every KxK window of one image plane, issuing pixel/weight reads and
// MAC strobes per term, waits for the MAC's window sum, and hands each sum to
// the output buffer over valid/ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin a convolution (only looked at in IDLE)
//   busy                high in every state except IDLE
//   done                one-cycle pulse after the last output is accepted
//   pix_addr, wgt_addr  read addresses (memories have 1-cycle latency)
//   mac_en/clr/last     MAC strobes aligned with the memory read data
//   mac_done, mac_result  MAC window-sum return
//   out_valid, out_ready, out_addr, out_data  output handshake
//   err                 sticky: mac_done seen outside WAIT_MAC
// ----------------------------------------------------------------------------
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int STRIDE      = 1,
    parameter int ADDR_W      = 10,
    parameter int WADDR_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       pix_addr,
    output logic [WADDR_W-1:0]      wgt_addr,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic                    mac_last,
    input  logic                    mac_done,
    input  logic signed [ACC_W-1:0] mac_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_W-1:0]       out_addr,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    err
);

    conv_sched_state_t r_state;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_macEn;
    logic                    r_macClr;
    logic                    r_macLast;
    logic                    r_outValid;
    logic [ADDR_W-1:0]       r_outAddr;
    logic signed [ACC_W-1:0] r_outData;
    logic                    r_err;

    logic                    w_clear;
    logic                    w_step;
    logic                    w_nextWin;
    logic [ADDR_W-1:0]       w_pixAddr;
    logic [WADDR_W-1:0]      w_wgtAddr;
    logic [ADDR_W-1:0]       w_outAddr;
    logic                    w_firstTerm;
    logic                    w_lastTerm;
    logic                    w_lastWin;

    // Counters sit at the origin whenever we are idle, step once per issued
    // term, and move to the next window exactly when an output is accepted.
    assign w_clear   = (r_state == IDLE);
    assign w_step    = (r_state == ISSUE);
    assign w_nextWin = (r_state == WRITE) && out_ready;

    window_addr_gen #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .IMG_WIDTH   (IMG_WIDTH),
        .IMG_HEIGHT  (IMG_HEIGHT),
        .STRIDE      (STRIDE),
        .ADDR_W      (ADDR_W),
        .WADDR_W     (WADDR_W)
    ) u_addrGen (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_step      (w_step),
        .i_nextWin   (w_nextWin),
        .o_pixAddr   (w_pixAddr),
        .o_wgtAddr   (w_wgtAddr),
        .o_outAddr   (w_outAddr),
        .o_firstTerm (w_firstTerm),
        .o_lastTerm  (w_lastTerm),
        .o_lastWin   (w_lastWin)
    );

    // Scheduler FSM with registered outputs. The MAC strobes are the ISSUE
    // flags delayed by one register so they line up with the 1-cycle memory
    // read data; the last strobe of a window therefore lands in the first
    // WAIT_MAC cycle. busy/done/out_valid are set on the transition into the
    // state they belong to so they are valid for the whole state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_macEn    <= 1'b0;
            r_macClr   <= 1'b0;
            r_macLast  <= 1'b0;
            r_outValid <= 1'b0;
            r_outAddr  <= '0;
            r_outData  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_macEn   <= (r_state == ISSUE);
            r_macClr  <= (r_state == ISSUE) && w_firstTerm;
            r_macLast <= (r_state == ISSUE) && w_lastTerm;
            r_done    <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (w_lastTerm) begin
                        r_state <= WAIT_MAC;
                    end
                end
                WAIT_MAC: begin
                    if (mac_done) begin
                        r_outData  <= mac_result;
                        r_outAddr  <= w_outAddr;
                        r_outValid <= 1'b1;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        if (w_lastWin) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A stray MAC result is reported even if it coincides with an
            // accepted start, so this set overrides the clear above.
            if (mac_done && (r_state != WAIT_MAC)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pix_addr  = w_pixAddr;
    assign wgt_addr  = w_wgtAddr;
    assign mac_en    = r_macEn;
    assign mac_clr   = r_macClr;
    assign mac_last  = r_macLast;
    assign out_valid = r_outValid;
    assign out_addr  = r_outAddr;
    assign out_data  = r_outData;
    assign err       = r_err;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// ----------------------------------------------------------------------------
// tb_conv_window_scheduler
// Drives a 4x4 image / 3x3 kernel convolution through the scheduler with a
// behavioural pixel/weight memory and MAC around it, and compares the output
// stream against window sums computed directly from the memory contents.
// ----------------------------------------------------------------------------
module tb_conv_window_scheduler;

   localparam int K    = 3;
   localparam int IW   = 4;
   localparam int IH   = 4;
   localparam int ST   = 1;
   localparam int AW   = 10;
   localparam int WW   = 5;
   localparam int OW   = (IW - K) / ST + 1;
   localparam int OH   = (IH - K) / ST + 1;
   localparam int NWIN = OW * OH;
   localparam int NT   = K * K;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               busy;
   logic               done;
   logic [AW-1:0]      pix_addr;
   logic [WW-1:0]      wgt_addr;
   logic               mac_en;
   logic               mac_clr;
   logic               mac_last;
   logic               mac_done;
   logic signed [31:0] mac_result;
   logic               out_valid;
   logic               out_ready;
   logic [AW-1:0]      out_addr;
   logic signed [31:0] out_data;
   logic               err;

   int total = 0;
   int bad   = 0;

   logic signed [15:0] pixMem [IW*IH];
   logic signed [15:0] wgtMem [NT];
   logic signed [15:0] pixData;
   logic signed [15:0] wgtData;
   logic signed [31:0] acc;
   logic signed [31:0] prod;
   logic               macReply;
   logic               spurious;
   int                 macCnt;
   int                 prevPix;
   int                 prevWgt;

   int outAddrQ [$];
   int outDataQ [$];
   int doneCount;
   int issPix [$];
   int issWgt [$];
   bit issClr [$];
   bit issLast [$];
   int expData [NWIN];

   always #5 clk = ~clk;

   assign mac_done = macReply | spurious;

   conv_window_scheduler #(
      .KERNEL_SIZE (K),
      .IMG_WIDTH   (IW),
      .IMG_HEIGHT  (IH),
      .STRIDE      (ST),
      .ADDR_W      (AW),
      .WADDR_W     (WW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .pix_addr   (pix_addr),
      .wgt_addr   (wgt_addr),
      .mac_en     (mac_en),
      .mac_clr    (mac_clr),
      .mac_last   (mac_last),
      .mac_done   (mac_done),
      .mac_result (mac_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .err        (err)
   );

   // Environment around the DUT, evaluated mid-cycle: MAC consumes the
   // operands read on the previous cycle, answers two cycles after its last
   // term, memories then read the current addresses, and the output/done
   // traffic is logged.
   always @(negedge clk) begin
      if (rst) begin
         macCnt   = 0;
         macReply = 1'b0;
         acc      = '0;
      end else begin
         macReply = 1'b0;
         if (macCnt > 0) begin
            macCnt--;
            if (macCnt == 0) begin
               macReply   = 1'b1;
               mac_result = acc;
            end
         end
         if (mac_en) begin
            prod = pixData * wgtData;
            acc  = mac_clr ? prod : acc + prod;
            if (mac_last) macCnt = 2;
            issPix.push_back(prevPix);
            issWgt.push_back(prevWgt);
            issClr.push_back(mac_clr);
            issLast.push_back(mac_last);
         end
      end
      if (out_valid && out_ready) begin
         outAddrQ.push_back(int'(out_addr));
         outDataQ.push_back(int'(out_data));
      end
      if (done) doneCount++;
      prevPix = int'(pix_addr);
      prevWgt = int'(wgt_addr);
      pixData = (int'(pix_addr) < IW*IH) ? pixMem[pix_addr] : '0;
      wgtData = (int'(wgt_addr) < NT) ? wgtMem[wgt_addr] : '0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Window sums straight from the convolution definition.
   task automatic computeExpected();
      for (int w = 0; w < NWIN; w++) begin
         int orow = w / OW;
         int ocol = w % OW;
         int s = 0;
         for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
               s += int'(pixMem[(orow*ST + ky)*IW + ocol*ST + kx]) * int'(wgtMem[ky*K + kx]);
         expData[w] = s;
      end
   endtask

   task automatic loadIdentity();
      for (int i = 0; i < IW*IH; i++) pixMem[i] = 16'(i);
      for (int i = 0; i < NT; i++) wgtMem[i] = 16'sd1;
   endtask

   task automatic clearLogs();
      outAddrQ.delete();
      outDataQ.delete();
      issPix.delete();
      issWgt.delete();
      issClr.delete();
      issLast.delete();
      doneCount = 0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(input string name, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
      end
      tick();
   endtask

   task automatic checkOutputs(input string name);
      total++;
      if (outAddrQ.size() != NWIN) begin
         bad++;
         $display("[TB] FAIL %s_count: got %0d outputs, required %0d", name, outAddrQ.size(), NWIN);
      end
      for (int i = 0; i < NWIN && i < outAddrQ.size(); i++) begin
         total++;
         if (outAddrQ[i] !== i || outDataQ[i] !== expData[i]) begin
            bad++;
            $display("[TB] FAIL %s_out%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     name, i, outAddrQ[i], outDataQ[i], i, expData[i]);
         end
      end
      total++;
      if (doneCount != 1) begin
         bad++;
         $display("[TB] FAIL %s_doneCount: got %0d, required 1", name, doneCount);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s_busyAfter: got %b, required 0", name, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({busy, done, mac_en, mac_clr, mac_last, out_valid, err} !== 7'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got busy,done,en,clr,last,valid,err=%b, required 0000000",
                  {busy, done, mac_en, mac_clr, mac_last, out_valid, err});
      end
      total++;
      if (pix_addr !== '0 || wgt_addr !== '0) begin
         bad++;
         $display("[TB] FAIL reset_rdAddr: got pix=%0d wgt=%0d, required 0/0", pix_addr, wgt_addr);
      end
      total++;
      if (out_addr !== '0 || out_data !== '0) begin
         bad++;
         $display("[TB] FAIL reset_out: got addr=%0d data=%0d, required 0/0", out_addr, out_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      loadIdentity();
      computeExpected();
      clearLogs();
      pulseStart();
      waitDone("basic", 300);
      checkOutputs("basic");
   endtask

   task automatic test_addr_seq();
      loadIdentity();
      computeExpected();
      clearLogs();
      pulseStart();
      waitDone("addrSeq", 300);
      total++;
      if (issPix.size() != NWIN*NT) begin
         bad++;
         $display("[TB] FAIL addrSeq_terms: got %0d mac_en terms, required %0d", issPix.size(), NWIN*NT);
      end else begin
         // Window (1,1) is the fourth window.
         for (int j = 0; j < NT; j++) begin
            int idx = 3*NT + j;
            int ePix = (1*ST + j/K)*IW + 1*ST + j%K;
            total++;
            if (issPix[idx] != ePix || issWgt[idx] != j ||
                issClr[idx] != (j == 0) || issLast[idx] != (j == NT-1)) begin
               bad++;
               $display("[TB] FAIL addrSeq_term%0d: got pix=%0d wgt=%0d clr=%0d last=%0d, required pix=%0d wgt=%0d clr=%0d last=%0d",
                        j, issPix[idx], issWgt[idx], issClr[idx], issLast[idx], ePix, j, j == 0, j == NT-1);
            end
         end
         for (int w = 0; w < NWIN; w++) begin
            int nClr = 0;
            int nLast = 0;
            for (int j = 0; j < NT; j++) begin
               if (issClr[w*NT + j]) nClr += (j == 0) ? 1 : 100;
               if (issLast[w*NT + j]) nLast += (j == NT-1) ? 1 : 100;
            end
            total++;
            if (nClr != 1 || nLast != 1) begin
               bad++;
               $display("[TB] FAIL addrSeq_strobes_win%0d: got clrScore=%0d lastScore=%0d, required 1/1", w, nClr, nLast);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      loadIdentity();
      computeExpected();
      clearLogs();
      pulseStart();
      while (!(out_valid === 1'b1 && out_addr === 10'd1) && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (!(out_valid === 1'b1 && out_addr === 10'd1)) begin
         bad++;
         $display("[TB] FAIL bp_reach: output 1 never presented, out_valid=%b out_addr=%0d", out_valid, out_addr);
      end
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || out_addr !== 10'd1 || out_data !== expData[1] || mac_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_hold%0d: got valid=%b addr=%0d data=%0d mac_en=%b, required 1/1/%0d/0",
                     c, out_valid, out_addr, out_data, mac_en, expData[1]);
         end
      end
      out_ready = 1'b1;
      waitDone("bp", 300);
      checkOutputs("bp");
   endtask

   task automatic test_reset_midrun();
      int n = 0;
      loadIdentity();
      computeExpected();
      clearLogs();
      pulseStart();
      while (outAddrQ.size() < 2 && n < 200) begin
         tick();
         n++;
      end
      repeat (3) tick();
      rst = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || mac_en !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rstMid_flags: got busy=%b mac_en=%b out_valid=%b done=%b, required all 0",
                  busy, mac_en, out_valid, done);
      end
      rst = 1'b0;
      repeat (15) tick();
      total++;
      if (doneCount != 0 || outAddrQ.size() != 2 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rstMid_aborted: got done=%0d outputs=%0d busy=%b, required 0/2/0",
                  doneCount, outAddrQ.size(), busy);
      end
      clearLogs();
      pulseStart();
      waitDone("rstMid", 300);
      checkOutputs("rstMid");
   endtask

   task automatic test_spurious();
      loadIdentity();
      computeExpected();
      clearLogs();
      spurious = 1'b1;
      tick();
      spurious = 1'b0;
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("[TB] FAIL spur_errSet: got err=%b, required 1", err);
      end
      repeat (20) tick();
      total++;
      if (outAddrQ.size() != 0 || busy !== 1'b0 || err !== 1'b1) begin
         bad++;
         $display("[TB] FAIL spur_idle: got outputs=%0d busy=%b err=%b, required 0/0/1",
                  outAddrQ.size(), busy, err);
      end
      pulseStart();
      total++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL spur_errClear: got err=%b busy=%b, required 0/1", err, busy);
      end
      waitDone("spur", 300);
      checkOutputs("spur");
   endtask

   task automatic test_start_held();
      int n = 0;
      loadIdentity();
      computeExpected();
      clearLogs();
      start = 1'b1;
      while (done !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      total++;
      if (done !== 1'b1 || outAddrQ.size() != NWIN) begin
         bad++;
         $display("[TB] FAIL held_firstRun: got done=%b outputs=%0d, required 1/%0d", done, outAddrQ.size(), NWIN);
      end
      tick();
      total++;
      if (busy !== 1'b0 || doneCount != 1) begin
         bad++;
         $display("[TB] FAIL held_idleGap: got busy=%b doneCount=%0d, required 0/1", busy, doneCount);
      end
      tick();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL held_restart: got busy=%b, required 1", busy);
      end
      start = 1'b0;
      waitDone("held2", 300);
      total++;
      if (doneCount != 2 || outAddrQ.size() != 2*NWIN) begin
         bad++;
         $display("[TB] FAIL held_secondRun: got doneCount=%0d outputs=%0d, required 2/%0d",
                  doneCount, outAddrQ.size(), 2*NWIN);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         int n = 0;
         for (int i = 0; i < IW*IH; i++) pixMem[i] = 16'($urandom_range(0, 4095) - 2048);
         for (int i = 0; i < NT; i++) wgtMem[i] = 16'($urandom_range(0, 255) - 128);
         computeExpected();
         clearLogs();
         pulseStart();
         while (done !== 1'b1 && n < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
         out_ready = 1'b1;
         total++;
         if (done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rand%0d_timeout: done=%b after %0d cycles, required 1", it, done, n);
         end
         tick();
         checkOutputs($sformatf("rand%0d", it));
         total++;
         if (err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rand%0d_err: got err=%b, required 0", it, err);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      out_ready  = 1'b1;
      spurious   = 1'b0;
      macReply   = 1'b0;
      mac_result = '0;
      macCnt     = 0;
      acc        = '0;
      doneCount  = 0;
      loadIdentity();

      test_reset();
      test_basic();
      test_addr_seq();
      test_backpressure();
      test_reset_midrun();
      test_spurious();
      test_start_held();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
